// File: rtl/cart_mem_arb_pkg.sv
// Shared types and defaults for the cartridge memory arbiter.
package cart_mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  typedef enum logic {
    PortA,
    PortB
  } port_id_e;

  localparam int unsigned STARVE_LIM_DEF = 4;
  localparam int unsigned ADDR_W_DEF     = 23;

endpackage

// File: rtl/cart_mem_arb_port.sv
// Per-requester front end: busy tracking, read-data register, ACK pulse and,
// when CART_MEM_ARB_BUF_EN is defined, a one-word read buffer with hit compare.
module cart_mem_arb_port
  import cart_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        we_i,
  input  logic              done_i,
  input  logic              rd_i,
  input  logic [15:0]       mem_di_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              owner_i,
  input  logic              inval_i,
  output logic              pend_o,
  output logic              ack_o,
  output logic [15:0]       do_o
);

  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        hit_q, hit_d;
  logic [15:0] do_q, do_d;
  logic        hit;
  logic [15:0] hit_data;

`ifdef CART_MEM_ARB_BUF_EN
  logic              buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [15:0]       buf_data_q, buf_data_d;
  logic              inval_match;

  always_comb begin
    // A write to this address retiring right now must not be bypassed by a stale hit.
    inval_match = inval_i && (mem_addr_i == addr_i);
    hit = buf_vld_q && req_i && !busy_q && !owner_i && (we_i == 2'b00) &&
          (buf_addr_q == addr_i) && !inval_match;
    hit_data   = buf_data_q;
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    if (done_i && rd_i) begin
      buf_vld_d  = 1'b1;
      buf_addr_d = mem_addr_i;
      buf_data_d = mem_di_i;
    end else if (inval_i && (buf_addr_q == mem_addr_i)) begin
      buf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end
`else
  logic unused_buf;
  assign unused_buf = ^{addr_i, we_i, owner_i, inval_i, mem_addr_i};
  assign hit        = 1'b0;
  assign hit_data   = '0;
`endif

  always_comb begin
    hit_d  = hit;
    busy_d = busy_q;
    if (done_i || hit) begin
      busy_d = 1'b1;
    end else if (!req_i) begin
      busy_d = 1'b0;
    end
    ack_d = done_i || hit_q;
    do_d  = do_q;
    if (done_i && rd_i) begin
      do_d = mem_di_i;
    end else if (hit_q) begin
      do_d = hit_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      hit_q  <= 1'b0;
      do_q   <= '0;
    end else begin
      busy_q <= busy_d;
      ack_q  <= ack_d;
      hit_q  <= hit_d;
      do_q   <= do_d;
    end
  end

  assign pend_o = req_i && !busy_q && !hit;
  assign ack_o  = ack_q;
  assign do_o   = do_q;

endmodule

// File: rtl/cart_mem_arb.sv
// Two-port arbiter (MD 68K cart side = A, 32X SH-2 window = B) onto one SDRAM channel.
// Optional per-port read buffers are enabled by defining CART_MEM_ARB_BUF_EN.
module cart_mem_arb
  import cart_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_di,
  input  logic [1:0]        a_we,
  input  logic              a_req,
  output logic              a_ack,
  output logic [15:0]       a_do,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_di,
  input  logic [1:0]        b_we,
  input  logic              b_req,
  output logic              b_ack,
  output logic [15:0]       b_do,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_do,
  output logic [1:0]        mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_di
);

  localparam int unsigned    CntW   = $clog2(STARVE_LIM + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIM);

  state_e            state_q, state_d;
  port_id_e          grant_q, grant_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_do_q, mem_do_d;
  logic [1:0]        mem_we_q, mem_we_d;
  logic              mem_req_q, mem_req_d;
  logic [CntW-1:0]   starve_q, starve_d;

  logic a_pend, b_pend;
  logic a_done, b_done;
  logic a_owner, b_owner;
  logic inval, mem_rd;

  assign mem_rd  = (mem_we_q == 2'b00);
  assign a_owner = (state_q != StIdle) && (grant_q == PortA);
  assign b_owner = (state_q != StIdle) && (grant_q == PortB);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mem_addr_d = mem_addr_q;
    mem_do_d   = mem_do_q;
    mem_we_d   = mem_we_q;
    mem_req_d  = mem_req_q;
    starve_d   = starve_q;
    a_done     = 1'b0;
    b_done     = 1'b0;
    inval      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (a_pend || b_pend) begin
          // A wins ties unless B has already waited out STARVE_LIM A grants.
          if (a_pend && !(b_pend && (starve_q == CntMax))) begin
            grant_d    = PortA;
            mem_addr_d = a_addr;
            mem_do_d   = a_di;
            mem_we_d   = a_we;
          end else begin
            grant_d    = PortB;
            mem_addr_d = b_addr;
            mem_do_d   = b_di;
            mem_we_d   = b_we;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        mem_req_d = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          a_done    = (grant_q == PortA);
          b_done    = (grant_q == PortB);
          state_d   = StDone;
        end
      end
      StDone: begin
        inval = !mem_rd;
        if ((grant_q == PortB) || !b_req) begin
          starve_d = '0;
        end else if (b_pend && (starve_q != CntMax)) begin
          starve_d = starve_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= PortA;
      mem_addr_q <= '0;
      mem_do_q   <= '0;
      mem_we_q   <= '0;
      mem_req_q  <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mem_addr_q <= mem_addr_d;
      mem_do_q   <= mem_do_d;
      mem_we_q   <= mem_we_d;
      mem_req_q  <= mem_req_d;
      starve_q   <= starve_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_do   = mem_do_q;
  assign mem_we   = mem_we_q;
  assign mem_req  = mem_req_q;

  cart_mem_arb_port #(
    .ADDR_W(ADDR_W)
  ) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (a_req),
    .addr_i    (a_addr),
    .we_i      (a_we),
    .done_i    (a_done),
    .rd_i      (mem_rd),
    .mem_di_i  (mem_di),
    .mem_addr_i(mem_addr_q),
    .owner_i   (a_owner),
    .inval_i   (inval),
    .pend_o    (a_pend),
    .ack_o     (a_ack),
    .do_o      (a_do)
  );

  cart_mem_arb_port #(
    .ADDR_W(ADDR_W)
  ) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (b_req),
    .addr_i    (b_addr),
    .we_i      (b_we),
    .done_i    (b_done),
    .rd_i      (mem_rd),
    .mem_di_i  (mem_di),
    .mem_addr_i(mem_addr_q),
    .owner_i   (b_owner),
    .inval_i   (inval),
    .pend_o    (b_pend),
    .ack_o     (b_ack),
    .do_o      (b_do)
  );

endmodule
